// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and the round-robin search used by the arbiter and its bench.
package mux_rr_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int STAT_W = 16;

    // Returns the first requester after last_idx (wrapping); last_idx when none pending.
    function automatic int rr_next(input logic [15:0] req, input int last_idx, input int n);
        int idx;
        int c;
        idx = last_idx;
        for (int k = n; k >= 1; k--) begin
            c = (last_idx + k) % n;
            if (req[c[3:0]]) begin
                idx = c;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Combinational round-robin picker: next pending requester after last_idx.
module mux_rr_pick
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_idx,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    logic [15:0] req_ext_s;

    // Zero-extend into the fixed width the shared search function takes.
    always_comb begin
        req_ext_s          = 16'h0000;
        req_ext_s[N-1:0]   = req;
        idx                = IW'(rr_next(req_ext_s, int'(last_idx), N));
        any                = |req;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter sharing one valid/ready channel between N lanes.
// Optional per-lane grant counters enabled by MUX_RR_ARBITER_STATS_EN.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_data,
    output logic [N-1:0]         req_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    input  logic                 out_ready,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
`ifdef MUX_RR_ARBITER_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [N*STAT_W-1:0]  grant_cnt
`endif
);
    localparam int IW = $clog2(N);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   grant_idx_q, grant_idx_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [IW-1:0]   pick_idx_s;
    logic            pick_any_s;
    logic            sel_valid_s;
    logic [W-1:0]    sel_data_s;
    logic            xfer_s;

    mux_rr_pick #(.N(N)) u_pick (
        .req      (req_valid),
        .last_idx (grant_idx_q),
        .idx      (pick_idx_s),
        .any      (pick_any_s)
    );

    // Channel mux: the granted lane is wired straight through while in GRANT.
    always_comb begin
        sel_valid_s = req_valid[grant_idx_q];
        sel_data_s  = req_data[grant_idx_q*W +: W];
        req_ready   = {N{1'b0}};
        if (state_q == GRANT) begin
            out_valid              = sel_valid_s;
            out_data               = sel_data_s;
            req_ready[grant_idx_q] = out_ready;
        end else begin
            out_valid = 1'b0;
            out_data  = {W{1'b0}};
        end
        xfer_s = out_valid & out_ready;
    end

    // Next-state logic; a release always passes through IDLE for one bubble cycle.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        beat_d      = beat_q;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    state_d     = GRANT;
                    grant_d     = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
                    grant_idx_d = pick_idx_s;
                    beat_d      = {BW{1'b0}};
                end else begin
                    grant_d = {N{1'b0}};
                end
            end
            GRANT: begin
                if (!sel_valid_s || (xfer_s && (beat_q == LAST_BEAT))) begin
                    state_d = IDLE;
                    grant_d = {N{1'b0}};
                    beat_d  = {BW{1'b0}};
                end else if (xfer_s) begin
                    beat_d = beat_q + BW'(1'b1);
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = {N{1'b0}};
                beat_d  = {BW{1'b0}};
            end
        endcase
    end

    // FSM registers; reset index N-1 makes requester 0 the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= {N{1'b0}};
            grant_idx_q <= IW'(N - 1);
            beat_q      <= {BW{1'b0}};
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            beat_q      <= beat_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;

`ifdef MUX_RR_ARBITER_STATS_EN
    logic [N-1:0][STAT_W-1:0] cnt_q, cnt_d;

    // Saturating per-lane grant counters; clear wins over a same-cycle grant.
    always_comb begin
        cnt_d = cnt_q;
        if (stat_clr) begin
            cnt_d = {(N*STAT_W){1'b0}};
        end else if ((state_q == IDLE) && pick_any_s) begin
            if (cnt_q[pick_idx_s] != {STAT_W{1'b1}}) begin
                cnt_d[pick_idx_s] = cnt_q[pick_idx_s] + STAT_W'(1'b1);
            end else begin
                cnt_d[pick_idx_s] = cnt_q[pick_idx_s];
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {(N*STAT_W){1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin controller that shares one output channel, built on a 2:1 mux tree, between N requesters.
- Sequences the mux select so that one granted requester owns the channel for a burst of up to MAX_BURST beats.
- Uses valid/ready handshakes on both sides.
- Sits between the per-lane producers and the single downstream consumer in the combinational-logic exercise datapath.

Parameters:
N, 4, number of requesters (2..16)
W, 8, data width per requester
MAX_BURST, 4, max beats transferred per grant (1..256)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  N  per-requester valid
req_data  input  N*W  per-requester data, lane i at bits [i*W +: W]
req_ready  output  N  per-requester ready
out_valid  output  1  channel valid
out_data  output  W  channel data (muxed)
out_ready  input  1  downstream ready
grant  output  N  one-hot grant, 0 when idle
grant_idx  output  $clog2(N)  index of current/last grant

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, grant=0, grant_idx=N-1 (so requester 0 wins first).
  - Beat counter=0, out_valid=0, req_ready=0.
  - out_data is don't-care but driven 0 while idle.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid, pick the first set bit searching upward from grant_idx+1, wrapping N-1 to 0.
  - Register grant/grant_idx and go to GRANT next cycle. Latency from req_valid to grant is 1 cycle.
  - If no req_valid, stay in IDLE with grant=0.
- GRANT, with sel=grant_idx:
  - out_valid=req_valid[sel]
  - out_data=req_data[sel]
  - req_ready[sel]=out_ready
  - All other req_ready=0.
  - These paths are combinational through the mux, with no added latency.
- Transfer = out_valid && out_ready. Each transfer increments the beat counter.
- Release (GRANT -> IDLE, grant cleared next cycle, grant_idx retained) when either:
  - a transfer occurs with beat counter == MAX_BURST-1, or
  - req_valid[sel]==0.
- On release the beat counter resets to 0. There is one idle bubble cycle between grants; this is required.
- A requester that keeps valid high is re-granted only after every other pending requester has had a grant (round-robin fairness).
- Simultaneous requests in IDLE: the lowest index above grant_idx (with wrap) wins.
- A single active requester with continuous valid gets MAX_BURST beats, 1 bubble, MAX_BURST beats, and so on.
- out_ready low stalls: the grant and counter hold, and no release occurs while req_valid[sel] stays high.
- Reset mid-burst: immediate return to reset values. The partial burst is abandoned with no recovery.
- Arbitration ignores req_data. X on req_data must not affect grant.

Optional Feature:
Macro: MUX_RR_ARBITER_STATS_EN
- Defined:
  - Adds input stat_clr (1) and output grant_cnt (N*16).
  - Per-requester 16-bit counter increments on each IDLE->GRANT for that requester and saturates at 16'hFFFF.
  - stat_clr synchronously zeroes all counters and takes priority over increment in the same cycle.
  - Reset clears the counters.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mux_rr_arbiter_pkg:
  - state enum state_t {IDLE, GRANT}
  - STAT_W=16 localparam
  - function rr_next(req, last_idx) returning the index (used by the RTL and by the bench model).
- Sub-module mux_rr_pick: purely combinational round-robin picker (req, last_idx -> idx, any).
- Top instantiates mux_rr_pick and holds the FSM, the counter and the output mux.

Test Plan:
Settings N=4, W=8, MAX_BURST=4 unless stated.
- Reset check: hold rst_n=0 with random inputs -> grant=0, out_valid=0, req_ready=0. Release rst_n with req_valid=4'b0001 -> grant=4'b0001 one cycle later.
- Round-robin: req_valid=4'b1111 constant, out_ready=1 -> grants in order 0,1,2,3,0, each for 4 beats with 1 bubble between. out_data equals the granted lane's data on every beat.
- Early release and wrap: grant_idx=3, req_valid=4'b0101, lane 2 drops valid after 2 beats -> lane 0 granted first (wrap), then lane 2. Lane 2's grant ends after 2 beats.
- Backpressure: lane 1 granted, out_ready toggles 1,0,0,1,1,1 -> exactly 4 transfers, grant held through stalls, release after the 4th transfer.
- Async reset mid-burst: assert rst_n=0 between clock edges during beat 2 -> outputs go to reset values before the next edge, and the counter restarts at 0 after release.
- Stats (macro defined): lanes 0 and 2 request continuously for 8 grants -> grant_cnt lanes 0 and 2 = 4 each, lanes 1 and 3 = 0. stat_clr pulsed together with a grant -> count reads 0. Preloaded counter value 16'hFFFF stays saturated.
